// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road signal controller with timed phases
// MG -> MY -> AR1 -> SG -> SY -> AR2 -> MG and registered lamp outputs.
// Pedestrian walk support is compiled in only when TRAFFIC_WALK_EN is defined.
module traffic_phase_ctrl #(
    parameter int CNT_W  = 8,
    parameter int T_GM   = 20,
    parameter int T_Y    = 4,
    parameter int T_AR   = 2,
    parameter int T_GS   = 10,
    parameter int T_WALK = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_req,
    input  logic       walk_req,
    output logic       r_m,
    output logic       y_m,
    output logic       g_m,
    output logic       r_s,
    output logic       y_s,
    output logic       g_s,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5
    } phase_e;

    function automatic bit dur_ok(input int t);
        return (t >= 1) && ((longint'(t) - 64'sd1) < (64'sd1 <<< CNT_W));
    endfunction

    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("traffic_phase_ctrl: CNT_W out of range");
    end
    if (!dur_ok(T_GM) || !dur_ok(T_Y) || !dur_ok(T_AR) || !dur_ok(T_GS) || !dur_ok(T_WALK)) begin : g_bad_dur
        $error("traffic_phase_ctrl: phase duration does not fit the timer");
    end

    localparam logic [CNT_W-1:0] LD_GM = CNT_W'(T_GM - 1);
    localparam logic [CNT_W-1:0] LD_Y  = CNT_W'(T_Y - 1);
    localparam logic [CNT_W-1:0] LD_AR = CNT_W'(T_AR - 1);
    localparam logic [CNT_W-1:0] LD_GS = CNT_W'(T_GS - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    phase_e           state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic             go_req;
    logic [5:0]       lamps_nx;

    assign phase = state;

`ifdef TRAFFIC_WALK_EN
    localparam int               WALK_LEN = (T_WALK < T_GS) ? T_WALK : T_GS;
    localparam logic [CNT_W-1:0] WALK_THR = CNT_W'(T_GS - WALK_LEN);

    logic walk_pend, walk_pend_nx;
    logic walk_act, walk_act_nx;
    logic walk_nx;

    assign go_req = side_req | walk_pend | walk_req;
`else
    logic unused_walk_req;

    assign unused_walk_req = walk_req;
    assign go_req          = side_req;
    assign walk            = 1'b0;
`endif

    // Next phase and timer: timed phases leave when the timer reads zero
    always_comb begin
        state_nx = state;
        timer_nx = timer - ONE;
        case (state)
            MG: begin
                if (timer == '0) begin
                    timer_nx = '0;
                    if (go_req) begin
                        state_nx = MY;
                        timer_nx = LD_Y;
                    end
                end
            end
            MY: if (timer == '0) begin
                state_nx = AR1;
                timer_nx = LD_AR;
            end
            AR1: if (timer == '0) begin
                state_nx = SG;
                timer_nx = LD_GS;
            end
            SG: if (timer == '0) begin
                state_nx = SY;
                timer_nx = LD_Y;
            end
            SY: if (timer == '0) begin
                state_nx = AR2;
                timer_nx = LD_AR;
            end
            AR2: if (timer == '0) begin
                state_nx = MG;
                timer_nx = LD_GM;
            end
            default: begin
                state_nx = AR2;
                timer_nx = LD_AR;
            end
        endcase
    end

    // Lamp pattern {r_m, y_m, g_m, r_s, y_s, g_s} for the phase being entered
    always_comb begin
        lamps_nx = 6'b100_100;
        case (state_nx)
            MG:      lamps_nx = 6'b001_100;
            MY:      lamps_nx = 6'b010_100;
            SG:      lamps_nx = 6'b100_001;
            SY:      lamps_nx = 6'b100_010;
            default: lamps_nx = 6'b100_100;
        endcase
    end

    // Phase register with lamps registered alongside it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                        <= AR2;
            timer                        <= LD_AR;
            {r_m, y_m, g_m, r_s, y_s, g_s} <= 6'b100_100;
        end else begin
            state                        <= state_nx;
            timer                        <= timer_nx;
            {r_m, y_m, g_m, r_s, y_s, g_s} <= lamps_nx;
        end
    end

`ifdef TRAFFIC_WALK_EN
    // Walk request latching; the AR1->SG hand-off consumes the request, so a
    // press on that same cycle is absorbed into this visit rather than re-armed
    always_comb begin
        walk_pend_nx = walk_pend | walk_req;
        walk_act_nx  = walk_act;
        if (state == AR1 && state_nx == SG) begin
            walk_pend_nx = 1'b0;
            walk_act_nx  = walk_pend | walk_req;
        end else if (state_nx != SG) begin
            walk_act_nx = 1'b0;
        end
        walk_nx = walk_act_nx && (state_nx == SG) && (timer_nx >= WALK_THR);
    end

    // Walk state registers, cleared by reset so a pending press is dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            walk_pend <= 1'b0;
            walk_act  <= 1'b0;
            walk      <= 1'b0;
        end else begin
            walk_pend <= walk_pend_nx;
            walk_act  <= walk_act_nx;
            walk      <= walk_nx;
        end
    end
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed-vector bench for traffic_phase_ctrl (T_GM=8, T_Y=3, T_AR=2,
// T_GS=6, T_WALK=4). Walk scenarios run when TRAFFIC_WALK_EN is defined,
// otherwise walk_req-only stimulus must leave the controller in MG.
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       side_req = 1'b0;
    logic       walk_req = 1'b0;
    logic       r_m, y_m, g_m, r_s, y_s, g_s, walk;
    logic [2:0] phase;

    typedef struct {
        logic       rst_n;
        logic       side;
        logic       wreq;
        logic [2:0] phase;
        logic       walk;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    traffic_phase_ctrl #(
        .CNT_W (8),
        .T_GM  (8),
        .T_Y   (3),
        .T_AR  (2),
        .T_GS  (6),
        .T_WALK(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .side_req(side_req),
        .walk_req(walk_req),
        .r_m     (r_m),
        .y_m     (y_m),
        .g_m     (g_m),
        .r_s     (r_s),
        .y_s     (y_s),
        .g_s     (g_s),
        .walk    (walk),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    // Expected {r_m, y_m, g_m, r_s, y_s, g_s} for a phase code
    function automatic logic [5:0] lamps_of(input logic [2:0] p);
        case (p)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd3:    return 6'b100_001;
            3'd4:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic add(input logic r, input logic s, input logic w,
                       input logic [2:0] p, input logic wk, input int n);
        vec_t v;
        v.rst_n = r;
        v.side  = s;
        v.wreq  = w;
        v.phase = p;
        v.walk  = wk;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check_out(input int idx, input logic [2:0] ep, input logic ew);
        logic [9:0] act, exp;
        act = {phase, r_m, y_m, g_m, r_s, y_s, g_s, walk};
        exp = {ep, lamps_of(ep), ew};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec[%0d]: got phase=%0d lamps=%b walk=%b, want phase=%0d lamps=%b walk=%b",
                     idx, act[9:7], act[6:1], act[0], ep, exp[6:1], ew);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        int edges;
        int sg_len;

        // Reset, release, MG held with no requests
        add(0, 0, 0, 5, 0, 2);
        add(1, 0, 0, 5, 0, 1);
        add(1, 0, 0, 0, 0, 12);
        // Constant side request from MG entry: full cycle, walk never lit
        add(0, 0, 0, 5, 0, 1);
        add(1, 1, 0, 5, 0, 1);
        add(1, 1, 0, 0, 0, 8);
        add(1, 1, 0, 1, 0, 3);
        add(1, 1, 0, 2, 0, 2);
        add(1, 1, 0, 3, 0, 6);
        add(1, 1, 0, 4, 0, 3);
        add(1, 1, 0, 5, 0, 2);
        add(1, 1, 0, 0, 0, 8);
        // Side request dropped once MY has started: cycle still completes
        add(1, 1, 0, 1, 0, 1);
        add(1, 0, 0, 1, 0, 2);
        add(1, 0, 0, 2, 0, 2);
        add(1, 0, 0, 3, 0, 6);
        add(1, 0, 0, 4, 0, 3);
        add(1, 0, 0, 5, 0, 2);
        add(1, 0, 0, 0, 0, 10);
`ifdef TRAFFIC_WALK_EN
        // Walk pulse during MG cycle 3: MG exits after cycle 8, walk 4 of 6 SG cycles
        add(0, 0, 0, 5, 0, 1);
        add(1, 0, 0, 5, 0, 1);
        add(1, 0, 0, 0, 0, 3);
        add(1, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 4);
        add(1, 0, 0, 1, 0, 3);
        add(1, 0, 0, 2, 0, 2);
        add(1, 0, 0, 3, 1, 4);
        add(1, 0, 0, 3, 0, 2);
        add(1, 0, 0, 4, 0, 3);
        add(1, 0, 0, 5, 0, 2);
        add(1, 0, 0, 0, 0, 12);
        // Walk press exactly on the AR1->SG cycle: served now, not re-armed
        add(1, 1, 0, 1, 0, 1);
        add(1, 0, 0, 1, 0, 2);
        add(1, 0, 0, 2, 0, 2);
        add(1, 0, 1, 3, 1, 1);
        add(1, 0, 0, 3, 1, 3);
        add(1, 0, 0, 3, 0, 2);
        add(1, 0, 0, 4, 0, 3);
        add(1, 0, 0, 5, 0, 2);
        add(1, 0, 0, 0, 0, 12);
        // Reset during walk-active SG with a fresh press pending: press is lost
        add(1, 0, 1, 1, 0, 1);
        add(1, 0, 0, 1, 0, 2);
        add(1, 0, 0, 2, 0, 2);
        add(1, 0, 0, 3, 1, 1);
        add(1, 0, 1, 3, 1, 1);
        add(0, 0, 0, 5, 0, 1);
        add(1, 0, 0, 5, 0, 1);
        add(1, 0, 0, 0, 0, 12);
`else
        // Walk button has no effect without pedestrian support
        add(1, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 3);
        add(1, 0, 1, 0, 0, 5);
        add(1, 0, 0, 0, 0, 4);
`endif

        foreach (vecs[i]) begin
            rst_n    = vecs[i].rst_n;
            side_req = vecs[i].side;
            walk_req = vecs[i].wreq;
            @(posedge clk);
            #1;
            check_out(i, vecs[i].phase, vecs[i].walk);
        end

        // From MG at timer zero, a side request reaches SG after 1+3+2 edges
        side_req = 1'b1;
        walk_req = 1'b0;
        edges = 0;
        while (phase != 3'd3 && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_int("edges_to_sg", edges, 6);
        side_req = 1'b0;

        // SG lasts exactly T_GS cycles
        sg_len = 0;
        while (phase == 3'd3 && sg_len < 20) begin
            @(posedge clk);
            #1;
            sg_len++;
        end
        check_int("sg_length", sg_len, 6);
        check_int("phase_after_sg", int'(phase), 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
